gb_frame_sequencer: RTL and testbench

GB_FRAME_SEQUENCER -- requirements
Module: gb_frame_sequencer

---
 rtl/gb_apu_pkg.sv | 9 +
 rtl/gb_frame_sequencer.sv | 98 +++++++++
 tb/tb_gb_frame_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/gb_apu_pkg.sv
// Shared APU constants: which frame-sequencer steps clock which channel functions.
// Bit n of each mask is set when step n produces that pulse.
package gb_apu_pkg;

    localparam logic [7:0] STEP_LEN_MASK   = 8'b0101_0101;
    localparam logic [7:0] STEP_SWEEP_MASK = 8'b0100_0100;
    localparam logic [7:0] STEP_ENV_MASK   = 8'b1000_0000;

endpackage

// File: rtl/gb_frame_sequencer.sv
// Game Boy APU frame sequencer: turns a 512 Hz tick into the 8-step pattern of
// length (256 Hz), sweep (128 Hz) and envelope (64 Hz) clock pulses.
module gb_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter int USE_DIV_INPUT = 1,
    parameter int DIV_PERIOD    = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_on,
    input  logic       div_bit,
    output logic       clk_length_ctr,
    output logic       clk_vol_env,
    output logic       clk_sweep,
    output logic [2:0] step,
    output logic       next_no_length
);

    logic       div_prev_reg;
    logic       tick;
    logic [2:0] ptr_reg, ptr_next;
    logic [2:0] step_reg, step_next;
    logic       len_reg, len_next;
    logic       env_reg, env_next;
    logic       sweep_reg, sweep_next;

    // Tracked even while powered off so a level already low at power-on is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_prev_reg <= 1'b0;
        end else begin
            div_prev_reg <= div_bit;
        end
    end

    generate
        if (USE_DIV_INPUT != 0) begin : g_div_tick
            assign tick = div_prev_reg & ~div_bit;
        end else begin : g_int_tick
            localparam int CW = (DIV_PERIOD > 1) ? $clog2(DIV_PERIOD) : 1;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (!apu_on || cnt_reg == CW'(DIV_PERIOD - 1)) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign tick = (cnt_reg == CW'(DIV_PERIOD - 1));
        end
    endgenerate

    always_comb begin
        ptr_next   = ptr_reg;
        step_next  = step_reg;
        len_next   = 1'b0;
        env_next   = 1'b0;
        sweep_next = 1'b0;
        if (!apu_on) begin
            ptr_next  = 3'd0;
            step_next = 3'd0;
        end else if (tick) begin
            len_next   = STEP_LEN_MASK[ptr_reg];
            sweep_next = STEP_SWEEP_MASK[ptr_reg];
            env_next   = STEP_ENV_MASK[ptr_reg];
            step_next  = ptr_reg;
            ptr_next   = ptr_reg + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg   <= 3'd0;
            step_reg  <= 3'd0;
            len_reg   <= 1'b0;
            env_reg   <= 1'b0;
            sweep_reg <= 1'b0;
        end else begin
            ptr_reg   <= ptr_next;
            step_reg  <= step_next;
            len_reg   <= len_next;
            env_reg   <= env_next;
            sweep_reg <= sweep_next;
        end
    end

    assign clk_length_ctr = len_reg;
    assign clk_vol_env    = env_reg;
    assign clk_sweep      = sweep_reg;
    assign step           = step_reg;
    assign next_no_length = ptr_reg[0];

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Directed bench for gb_frame_sequencer: vector table for the step pattern, plus
// hand sequences for power-off, async reset and the internal-divider build.
module tb_gb_frame_sequencer;

    logic       clk;
    logic       reset;
    logic       reset_int;
    logic       apu_on;
    logic       apu_on_int;
    logic       div_bit;

    logic       len_o, env_o, sweep_o, nnl_o;
    logic [2:0] step_o;
    logic       len_i, env_i, sweep_i, nnl_i;
    logic [2:0] step_i;

    int n_cmp = 0;
    int n_bad = 0;

    gb_frame_sequencer #(.USE_DIV_INPUT(1), .DIV_PERIOD(8192)) dut (
        .clk(clk), .reset(reset), .apu_on(apu_on), .div_bit(div_bit),
        .clk_length_ctr(len_o), .clk_vol_env(env_o), .clk_sweep(sweep_o),
        .step(step_o), .next_no_length(nnl_o)
    );

    gb_frame_sequencer #(.USE_DIV_INPUT(0), .DIV_PERIOD(16)) dut_int (
        .clk(clk), .reset(reset_int), .apu_on(apu_on_int), .div_bit(div_bit),
        .clk_length_ctr(len_i), .clk_vol_env(env_i), .clk_sweep(sweep_i),
        .step(step_i), .next_no_length(nnl_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed observation: {len, sweep, env, step[2:0], next_no_length}
    typedef struct {
        logic       apu;
        logic       div;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [20];

    function automatic logic [6:0] obs_main();
        return {len_o, sweep_o, env_o, step_o, nnl_o};
    endfunction

    function automatic logic [6:0] obs_int();
        return {len_i, sweep_i, env_i, step_i, nnl_i};
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b ({len,sweep,env,step,nnl})", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_edges(input int n);
        for (int e = 0; e < n; e++) begin
            div_bit = 1'b0;
            cyc();
            div_bit = 1'b1;
            cyc();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #12;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int last_step;
        logic [6:0] e;

        reset      = 1'b1;
        reset_int  = 1'b1;
        apu_on     = 1'b0;
        apu_on_int = 1'b1;
        div_bit    = 1'b1;
        #2;
        check("reset_state", obs_main(), 7'b0);
        check("reset_state_int", obs_int(), 7'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 7'b0_0_0_000_0};
        vecs[1]  = '{1'b1, 1'b0, 7'b1_0_0_000_1};
        vecs[2]  = '{1'b1, 1'b0, 7'b0_0_0_000_1};
        vecs[3]  = '{1'b1, 1'b1, 7'b0_0_0_000_1};
        vecs[4]  = '{1'b1, 1'b0, 7'b0_0_0_001_0};
        vecs[5]  = '{1'b1, 1'b1, 7'b0_0_0_001_0};
        vecs[6]  = '{1'b1, 1'b0, 7'b1_1_0_010_1};
        vecs[7]  = '{1'b1, 1'b1, 7'b0_0_0_010_1};
        vecs[8]  = '{1'b1, 1'b0, 7'b0_0_0_011_0};
        vecs[9]  = '{1'b1, 1'b1, 7'b0_0_0_011_0};
        vecs[10] = '{1'b1, 1'b0, 7'b1_0_0_100_1};
        vecs[11] = '{1'b1, 1'b1, 7'b0_0_0_100_1};
        vecs[12] = '{1'b1, 1'b0, 7'b0_0_0_101_0};
        vecs[13] = '{1'b1, 1'b1, 7'b0_0_0_101_0};
        vecs[14] = '{1'b1, 1'b0, 7'b1_1_0_110_1};
        vecs[15] = '{1'b1, 1'b1, 7'b0_0_0_110_1};
        vecs[16] = '{1'b1, 1'b0, 7'b0_0_1_111_0};
        vecs[17] = '{1'b1, 1'b1, 7'b0_0_0_111_0};
        vecs[18] = '{1'b1, 1'b0, 7'b1_0_0_000_1};
        vecs[19] = '{1'b1, 1'b1, 7'b0_0_0_000_1};

        for (int i = 0; i < 20; i++) begin
            apu_on  = vecs[i].apu;
            div_bit = vecs[i].div;
            cyc();
            $display("vec %0d: apu_on=%b div_bit=%b -> %b (want %b)",
                     i, vecs[i].apu, vecs[i].div, obs_main(), vecs[i].exp);
            check($sformatf("vec%0d", i), obs_main(), vecs[i].exp);
        end

        // Power-off mid-sequence, then power-on with div_bit already low.
        do_reset();
        apu_on  = 1'b1;
        div_bit = 1'b1;
        cyc();
        run_edges(5);
        check("off_pre_step4", obs_main(), 7'b0_0_0_100_1);
        apu_on = 1'b0;
        cyc();
        check("off_clear", obs_main(), 7'b0);
        for (int t = 0; t < 3; t++) begin
            div_bit = ~div_bit;
            cyc();
            $display("off toggle %0d: div_bit=%b -> %b", t, div_bit, obs_main());
            check($sformatf("off_toggle%0d", t), obs_main(), 7'b0);
        end
        apu_on = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cyc();
            check($sformatf("on_low_hold%0d", t), obs_main(), 7'b0);
        end
        div_bit = 1'b1;
        cyc();
        check("on_rise", obs_main(), 7'b0);
        div_bit = 1'b0;
        cyc();
        $display("power-on first edge -> %b", obs_main());
        check("on_first_edge", obs_main(), 7'b1_0_0_000_1);

        // Asynchronous reset between edges after step 5.
        do_reset();
        apu_on  = 1'b1;
        div_bit = 1'b1;
        cyc();
        run_edges(6);
        check("pre_reset_step5", obs_main(), 7'b0_0_0_101_0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", obs_main(), 7'b0);
        #2;
        reset = 1'b0;
        cyc();
        div_bit = 1'b0;
        cyc();
        $display("post-reset first edge -> %b", obs_main());
        check("post_reset_edge", obs_main(), 7'b1_0_0_000_1);

        // Internal divider build, period 16.
        @(posedge clk);
        #1;
        reset_int = 1'b0;
        last_step = 0;
        for (int n = 1; n <= 144; n++) begin
            int k;
            cyc();
            k = ((n / 16) + 7) % 8;
            if (n % 16 == 0) begin
                last_step = k;
                e = {(k % 2 == 0) ? 1'b1 : 1'b0, (k == 2 || k == 6) ? 1'b1 : 1'b0,
                     (k == 7) ? 1'b1 : 1'b0, 3'(k), 1'((n / 16) % 2)};
                $display("int cycle %0d: step %0d -> %b (want %b)", n + 1, k, obs_int(), e);
            end else begin
                e = {3'b000, 3'(last_step), 1'((n / 16) % 2)};
            end
            check($sformatf("int_cyc%0d", n + 1), obs_int(), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
